// File: rtl/nonce_gen_mc_pkg.sv
// nonce_gen_pkg: shared types and constants for the multi-channel nonce
// generator.
//   state_t   - FSM encoding (also exported on the debug state port)
//   HDR_*     - block header geometry (20 x 32-bit words = 640 bits)
//   BEATS     - 64-bit beats per frame after the preamble
//   PREAMBLE  - first beat of every hashin frame
//   bswap32   - byte swap used to place the nonce into header word 0
//   sat32     - clamp a 40-bit intermediate to 32 bits
package nonce_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RANGE  = 3'd2,
    ST_SELECT = 3'd3,
    ST_EMIT   = 3'd4
  } state_t;

  localparam int HDR_WORDS = 20;
  localparam int HDR_BITS  = 640;
  localparam int BEATS     = 10;

  localparam logic [63:0] PREAMBLE = 64'h8000000000000280;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [31:0] sat32(input logic [39:0] v);
    return (v[39:32] != 8'd0) ? 32'hFFFFFFFF : v[31:0];
  endfunction

endpackage

// File: rtl/nonce_gen_mc_if.sv
// nonce_gen_mc_if: bundles the header input, software controls and the
// per-lane FIFO write ports of nonce_gen_mc.
//   master - the environment side (header source, software, FIFOs)
//   slave  - the generator side
//
// Handshake: a FIFO write on lane i happens in any cycle where the
// generator drives *_we[i]=1; the generator only does so when the
// matching *_full[i] is 0 in that same cycle. full is an inverse ready,
// sampled combinationally, and the data word is held stable until it is
// accepted. block_header_we is a plain qualifier with no back-pressure.
interface nonce_gen_mc_if #(
  parameter int NUM_CH = 4
);
  logic                  start;
  logic                  stop;
  logic [31:0]           block_header;
  logic                  block_header_we;
  logic [31:0]           nonce_size;
  logic [NUM_CH-1:0]     hashin_fifo_in_full;
  logic [NUM_CH-1:0]     nonce_fifo_full;
  logic [NUM_CH-1:0]     hashin_fifo_in_we;
  logic [63:0]           hashin_fifo_in_din;
  logic [NUM_CH-1:0]     nonce_fifo_we;
  logic [31:0]           nonce_fifo_din;
  logic                  stop_ack_nonce;
  logic [31:0]           nonce_end;
  logic [31:0]           nonce_cur;
  logic                  done;
  nonce_gen_pkg::state_t dbg_state;

  modport master (
    output start, stop, block_header, block_header_we, nonce_size,
           hashin_fifo_in_full, nonce_fifo_full,
    input  hashin_fifo_in_we, hashin_fifo_in_din, nonce_fifo_we,
           nonce_fifo_din, stop_ack_nonce, nonce_end, nonce_cur, done,
           dbg_state
  );

  modport slave (
    input  start, stop, block_header, block_header_we, nonce_size,
           hashin_fifo_in_full, nonce_fifo_full,
    output hashin_fifo_in_we, hashin_fifo_in_din, nonce_fifo_we,
           nonce_fifo_din, stop_ack_nonce, nonce_end, nonce_cur, done,
           dbg_state
  );
endinterface

// File: rtl/nonce_gen_mc_rr_pick.sv
// rr_pick: round-robin first-ready search.
//   ready_i - per-lane ready flags
//   ptr_i   - lane where the search starts (must be < N)
//   hit_o   - at least one lane is ready
//   idx_o   - first ready lane at or after ptr_i, wrapping
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] ready_i,
  input  logic [W-1:0] ptr_i,
  output logic         hit_o,
  output logic [W-1:0] idx_o
);

  // Walk from the farthest offset down to offset 0 so the nearest ready
  // lane is the last assignment and wins.
  always_comb begin
    int cand;
    hit_o = 1'b0;
    idx_o = '0;
    cand  = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      if (ready_i[cand]) begin
        hit_o = 1'b1;
        idx_o = W'(cand);
      end
    end
  end

endmodule

// File: rtl/nonce_gen_mc.sv
// nonce_gen_mc: loads a 20-word block header, derives this core's nonce
// slice [base + size*(COEF-1), base + size*COEF) and hands nonces out
// round-robin to NUM_CH hasher lanes. Each nonce produces an 11-beat
// hashin frame (preamble + 10 header beats) and one nonce FIFO write.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - nonce_gen_mc_if slave: header input, start/stop,
//              nonce_size, per-lane FIFO writes, status and debug state
module nonce_gen_mc
  import nonce_gen_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int NONCE_COEF = 1
) (
  input logic           clk,
  input logic           rst,
  nonce_gen_mc_if.slave bus
);

  localparam int LW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [39:0] COEF_LO = 40'(NONCE_COEF - 1);
  localparam logic [39:0] COEF_HI = 40'(NONCE_COEF);

  state_t                state_q;
  logic [HDR_BITS-1:0]   header_q;
  logic [HDR_BITS-1:0]   frame_q;
  logic [4:0]            wcnt_q;
  logic [LW-1:0]         ptr_q;
  logic [LW-1:0]         lane_q;
  logic [3:0]            beat_q;
  logic [31:0]           nonce_cur_q;
  logic [31:0]           nonce_end_q;
  logic                  done_q;
  logic                  stop_pend_q;

  // Lane selection: a lane is usable only when both of its FIFOs have room.
  logic [NUM_CH-1:0] lane_ready;
  logic              pick_hit;
  logic [LW-1:0]     pick_idx;

  assign lane_ready = ~bus.hashin_fifo_in_full & ~bus.nonce_fifo_full;

  rr_pick #(.N(NUM_CH), .W(LW)) u_pick (
    .ready_i (lane_ready),
    .ptr_i   (ptr_q),
    .hit_o   (pick_hit),
    .idx_o   (pick_idx)
  );

  // Slice bounds at 40 bits so overflow past 32 bits can be clamped.
  logic [39:0] start_w, end_w;
  logic [31:0] range_start, range_end;

  assign start_w     = {8'd0, header_q[31:0]} + ({8'd0, bus.nonce_size} * COEF_LO);
  assign end_w       = {8'd0, header_q[31:0]} + ({8'd0, bus.nonce_size} * COEF_HI);
  assign range_start = sat32(start_w);
  assign range_end   = sat32(end_w);

  logic        issue;
  logic [63:0] beat_word;

  assign issue = (state_q == ST_SELECT) && !bus.stop &&
                 (nonce_cur_q < nonce_end_q) && pick_hit;

  // Beat 0 is the top 64 bits of the frame, beat 9 the bottom.
  assign beat_word = frame_q[(BEATS - 1 - int'(beat_q)) * 64 +: 64];

  // FIFO writes are combinational from registered state and the full flags.
  logic [NUM_CH-1:0] hwe, nwe;
  logic [63:0]       hdin;
  logic [31:0]       ndin;

  always_comb begin
    hwe  = '0;
    nwe  = '0;
    hdin = '0;
    ndin = '0;
    if (issue) begin
      hwe[pick_idx] = 1'b1;
      nwe[pick_idx] = 1'b1;
      hdin          = PREAMBLE;
      ndin          = nonce_cur_q;
    end else if (state_q == ST_EMIT) begin
      // Data stays on the bus while the lane is full so the beat is held.
      hdin = beat_word;
      if (!bus.hashin_fifo_in_full[lane_q]) hwe[lane_q] = 1'b1;
    end
  end

  assign bus.hashin_fifo_in_we  = hwe;
  assign bus.hashin_fifo_in_din = hdin;
  assign bus.nonce_fifo_we      = nwe;
  assign bus.nonce_fifo_din     = ndin;
  assign bus.stop_ack_nonce     = (state_q == ST_IDLE);
  assign bus.nonce_end          = nonce_end_q;
  assign bus.nonce_cur          = nonce_cur_q;
  assign bus.done               = done_q;
  assign bus.dbg_state          = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      header_q    <= '0;
      frame_q     <= '0;
      wcnt_q      <= '0;
      ptr_q       <= '0;
      lane_q      <= '0;
      beat_q      <= '0;
      nonce_cur_q <= '0;
      nonce_end_q <= '0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          header_q    <= '0;
          wcnt_q      <= '0;
          ptr_q       <= '0;
          nonce_cur_q <= '0;
          stop_pend_q <= 1'b0;
          if (bus.start && !bus.stop) state_q <= ST_LOAD;
        end

        ST_LOAD: begin
          if (bus.stop) begin
            state_q <= ST_IDLE;
          end else if (bus.block_header_we) begin
            // Shift in from the top: after 20 words, word k sits at [32k+:32].
            header_q <= {bus.block_header, header_q[HDR_BITS-1:32]};
            if (wcnt_q == 5'(HDR_WORDS - 1)) state_q <= ST_RANGE;
            else                              wcnt_q  <= wcnt_q + 5'd1;
          end
        end

        ST_RANGE: begin
          if (bus.stop) begin
            state_q <= ST_IDLE;
          end else begin
            nonce_cur_q <= range_start;
            nonce_end_q <= range_end;
            if (range_start >= range_end) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_SELECT;
            end
          end
        end

        ST_SELECT: begin
          if (bus.stop) begin
            state_q <= ST_IDLE;
          end else if (nonce_cur_q >= nonce_end_q) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else if (pick_hit) begin
            frame_q     <= {header_q[HDR_BITS-1:32], bswap32(nonce_cur_q)};
            nonce_cur_q <= nonce_cur_q + 32'd1;
            lane_q      <= pick_idx;
            ptr_q       <= (pick_idx == LW'(NUM_CH - 1)) ? '0 : pick_idx + LW'(1);
            beat_q      <= '0;
            state_q     <= ST_EMIT;
          end
        end

        ST_EMIT: begin
          // A stop seen mid-frame is remembered; the frame always completes.
          if (bus.stop) stop_pend_q <= 1'b1;
          if (!bus.hashin_fifo_in_full[lane_q]) begin
            if (beat_q == 4'(BEATS - 1)) begin
              state_q <= (stop_pend_q || bus.stop) ? ST_IDLE : ST_SELECT;
            end else begin
              beat_q <= beat_q + 4'd1;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
